// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sharing of one combinational multiplier between two requesters
module mult_share_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_p,
  output logic               rsp_id,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t     state;
  logic       rr;
  logic [3:0] cnt;
  logic       grant0, grant1;
  // rr==0 favours req0 when both are valid
  assign grant0     = req0_valid & (~req1_valid | ~rr);
  assign grant1     = req1_valid & (~req0_valid | rr);
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign busy       = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      cnt       <= 4'd0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant0 | grant1) begin
          mul_a  <= grant1 ? req1_a : req0_a;
          mul_b  <= grant1 ? req1_b : req0_b;
          rsp_id <= grant1;
          rr     <= grant0;
          cnt    <= 4'(SETTLE - 1);
          state  <= WAIT;
        end
        WAIT: if (cnt == 4'd0) begin
          rsp_p     <= mul_p;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed checks of arbitration, latency, backpressure and reset abort
module tb_mult_share_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0, mul_a, mul_b;
  logic [31:0] mul_p, rsp_p;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
  logic        s_valid = 1'b0, s_ready, s_r1_ready, s_rsp_valid, s_rsp_id, s_busy;
  logic [15:0] s_a = '0, s_b = '0, s_mul_a, s_mul_b;
  logic [31:0] s_mul_p, s_rsp_p;
  int checks = 0, failures = 0;
  logic both_seen = 1'b0;

  always #5 clk = ~clk;

  assign mul_p   = 32'(mul_a) * 32'(mul_b);
  assign s_mul_p = 32'(s_mul_a) * 32'(s_mul_b);

  mult_share_ctrl #(.WIDTH(16), .SETTLE(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_id(rsp_id), .busy(busy)
  );

  mult_share_ctrl #(.WIDTH(16), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(s_valid), .req0_ready(s_ready), .req0_a(s_a), .req0_b(s_b),
    .req1_valid(1'b0), .req1_ready(s_r1_ready), .req1_a(16'd0), .req1_b(16'd0),
    .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_p(s_mul_p),
    .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_p(s_rsp_p), .rsp_id(s_rsp_id), .busy(s_busy)
  );

  always @(negedge clk) if (req0_ready && req1_ready) both_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] exp_p, input logic exp_id,
                          output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_p"}, rsp_p, exp_p);
    check({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_hs_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic stable, quiet;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_p", rsp_p, 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_mul", {mul_a, mul_b}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // T1 single op
    req0_valid = 1'b1; req0_a = 16'd300; req0_b = 16'd200;
    #1 check("t1_rdy", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req0_a = 16'd1; req0_b = 16'd1;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_mul", {mul_a, mul_b}, {16'd300, 16'd200});
    wait_rsp("t1", 32'h0000EA60, 1'b0, lat);
    check("t1_lat", 32'(lat), 32'd3);
    handshake("t1");
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_mul_hold", {mul_a, mul_b}, {16'd300, 16'd200});
    // T2 max operands
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
    #1 check("t2_rdy", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp("t2", 32'hFFFE0001, 1'b1, lat);
    handshake("t2");
    // T3 contention from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    both_seen = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd3;
    req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd5;
    wait_rsp("t3a", 32'd6, 1'b0, lat);
    handshake("t3a");
    wait_rsp("t3b", 32'd20, 1'b1, lat);
    handshake("t3b");
    wait_rsp("t3c", 32'd6, 1'b0, lat);
    req0_valid = 1'b0; req1_valid = 1'b0;
    handshake("t3c");
    check("t3_excl", 32'(both_seen), 32'd0);
    // T4 backpressure
    req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd9;
    @(negedge clk);
    req0_a = 16'd11;
    req1_valid = 1'b1;
    wait_rsp("t4", 32'd63, 1'b0, lat);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || rsp_p !== 32'd63 || rsp_id !== 1'b0 || req0_ready || req1_ready)
        stable = 1'b0;
    end
    check("t4_stable", 32'(stable), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    handshake("t4");
    check("t4_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4_single", 32'(rsp_valid), 32'd0);
    // T5 reset while cnt==1
    req0_valid = 1'b1; req0_a = 16'd100; req0_b = 16'd100;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_mul", {mul_a, mul_b}, 32'd0);
    check("t5_p", rsp_p, 32'd0);
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || busy) quiet = 1'b0;
    end
    check("t5_quiet", 32'(quiet), 32'd1);
    req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd6;
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp("t5", 32'd30, 1'b0, lat);
    check("t5_lat", 32'(lat), 32'd3);
    handshake("t5");
    // T6 SETTLE=1 instance
    s_valid = 1'b1; s_a = 16'h1234; s_b = 16'h0010;
    #1 check("t6_rdy", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    lat = 0;
    while (!s_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t6_lat", 32'(lat), 32'd1);
    check("t6_p", s_rsp_p, 32'h00012340);
    check("t6_id", 32'(s_rsp_id), 32'd0);
    @(negedge clk);
    check("t6_done", {30'd0, s_rsp_valid, s_busy}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
